// File: rtl/ps_stream_pkg.sv
// Shared types for the Passive Serial bitstream streamer: FSM states and
// error codes reported on err_code.
package ps_stream_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NCFG,
        S_WAIT_ST,
        S_FETCH,
        S_CAPT,
        S_SHIFT,
        S_TAIL,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TMO      = 2'd1;
    localparam logic [1:0] ERR_NSTATUS  = 2'd2;
    localparam logic [1:0] ERR_CONFDONE = 2'd3;

endpackage

// File: rtl/ps_dclk_gen.sv
// DCLK divider: toggles the level every HALF enabled cycles and flags the
// cycle before each rising/falling transition.
module ps_dclk_gen #(
    parameter int unsigned HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic dclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick = en && (cnt == LAST);
    assign rise = tick && !dclk;
    assign fall = tick && dclk;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            dclk <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt  <= '0;
                dclk <= !dclk;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps_bitstream_streamer.sv
// Reads a configuration image from on-chip memory port s2 and shifts it out
// over a Passive Serial link (nCONFIG/nSTATUS/CONF_DONE/DCLK/DATA0).
module ps_bitstream_streamer
    import ps_stream_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DCLK_HALF    = 4,
    parameter int unsigned NCFG_LOW_CYC = 512,
    parameter int unsigned NSTATUS_TMO  = 65536,
    parameter int unsigned EXTRA_DCLK   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W+1:0] len_bytes,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    output logic              ps_nconfig,
    input  logic              ps_nstatus,
    input  logic              ps_conf_done,
    output logic              ps_dclk,
    output logic              ps_data0
);

    localparam int unsigned LW = ADDR_W + 2;
    localparam int unsigned EW = $clog2(EXTRA_DCLK + 1);
    localparam int unsigned NW = $clog2(8 * EXTRA_DCLK + 1);

    state_t            state, state_n;
    logic [1:0]        code_n;
    logic [31:0]       timer;
    logic [ADDR_W-1:0] ptr;
    logic [LW-1:0]     remaining;
    logic [31:0]       shreg;
    logic [5:0]        bitcnt;
    logic              conf_seen, seen_now;
    logic [EW-1:0]     extra_cnt;
    logic [NW-1:0]     nocd_cnt;
    logic              in_load, start_ok;
    logic              dclk_en, dclk_clr, rise, fall;

    assign start_ok = (state == S_IDLE) && start;
    assign in_load  = (state == S_FETCH) || (state == S_CAPT) ||
                      (state == S_SHIFT) || (state == S_TAIL);
    assign seen_now = conf_seen || ps_conf_done;

    // Clearing on the next state forces DCLK low on the same edge that leaves
    // SHIFT/TAIL, so an abort never produces a late edge.
    assign dclk_en  = (state == S_SHIFT) || (state == S_TAIL);
    assign dclk_clr = (state_n != S_SHIFT) && (state_n != S_TAIL);

    ps_dclk_gen #(.HALF(DCLK_HALF)) u_dclk (
        .clk   (clk),
        .reset (reset),
        .en    (dclk_en),
        .clr   (dclk_clr),
        .dclk  (ps_dclk),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_n = state;
        code_n  = ERR_NONE;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_bytes == '0) begin
                        state_n = S_ERR;
                        code_n  = ERR_CONFDONE;
                    end else begin
                        state_n = S_NCFG;
                    end
                end
            end
            S_NCFG: begin
                if (timer == NCFG_LOW_CYC - 1) state_n = S_WAIT_ST;
            end
            S_WAIT_ST: begin
                if (ps_nstatus) begin
                    state_n = S_FETCH;
                end else if (timer == NSTATUS_TMO - 1) begin
                    state_n = S_ERR;
                    code_n  = ERR_TMO;
                end
            end
            S_FETCH: state_n = S_CAPT;
            S_CAPT:  state_n = S_SHIFT;
            S_SHIFT: begin
                if (fall && (bitcnt == 6'd1))
                    state_n = (remaining != '0) ? S_FETCH : S_TAIL;
            end
            S_TAIL: begin
                if (fall && (extra_cnt == EW'(EXTRA_DCLK))) begin
                    state_n = S_DONE;
                end else if (fall && !seen_now && (nocd_cnt == NW'(8 * EXTRA_DCLK - 1))) begin
                    state_n = S_ERR;
                    code_n  = ERR_CONFDONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (in_load && !ps_nstatus) begin
            state_n = S_ERR;
            code_n  = ERR_NSTATUS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            ptr       <= '0;
            remaining <= '0;
            shreg     <= '0;
            bitcnt    <= '0;
            conf_seen <= 1'b0;
            extra_cnt <= '0;
            nocd_cnt  <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state <= state_n;
            timer <= (state_n != state) ? '0 : timer + 32'd1;

            if (start_ok) begin
                ptr       <= base_addr;
                remaining <= len_bytes;
                done      <= 1'b0;
                error     <= 1'b0;
                err_code  <= ERR_NONE;
            end

            if (state == S_CAPT) begin
                shreg <= mem_readdata;
                ptr   <= ptr + ADDR_W'(1);
                if (remaining >= LW'(4)) begin
                    bitcnt    <= 6'd32;
                    remaining <= remaining - LW'(4);
                end else begin
                    bitcnt    <= {remaining[2:0], 3'b000};
                    remaining <= '0;
                end
            end

            if ((state == S_SHIFT) && fall) begin
                shreg  <= {1'b0, shreg[31:1]};
                bitcnt <= bitcnt - 6'd1;
            end

            if (state != S_TAIL) begin
                conf_seen <= 1'b0;
                extra_cnt <= '0;
                nocd_cnt  <= '0;
            end else begin
                if (ps_conf_done) conf_seen <= 1'b1;
                if (rise && seen_now) extra_cnt <= extra_cnt + EW'(1);
                if (fall && !seen_now) nocd_cnt <= nocd_cnt + NW'(1);
            end

            if (state_n == S_DONE) done <= 1'b1;
            if (state_n == S_ERR) begin
                error    <= 1'b1;
                err_code <= code_n;
            end
        end
    end

    assign busy           = in_load || (state == S_NCFG) || (state == S_WAIT_ST);
    assign ps_nconfig     = (state != S_NCFG);
    assign ps_data0       = (state == S_SHIFT) ? shreg[0] : (state == S_TAIL);
    assign mem_address    = ptr;
    assign mem_chipselect = (state == S_FETCH);
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;

endmodule

// File: tb/tb_ps_bitstream_streamer.sv
// Scoreboard bench: expected DATA0 bits are queued from the memory image at
// start; a monitor pops one per DCLK rise and also emulates the target FPGA.
module tb_ps_bitstream_streamer;

    localparam int unsigned AW    = 14;
    localparam int unsigned HALF  = 2;
    localparam int unsigned NCFG  = 16;
    localparam int unsigned TMO   = 64;
    localparam int unsigned EXTRA = 8;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] base_addr;
    logic [AW+1:0] len_bytes;
    logic          busy, done, error;
    logic [1:0]    err_code;
    logic [AW-1:0] mem_address;
    logic          mem_chipselect, mem_clken, mem_write;
    logic [3:0]    mem_byteenable;
    logic [31:0]   mem_readdata;
    logic          ps_nconfig, ps_nstatus, ps_conf_done, ps_dclk, ps_data0;

    logic [31:0] mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    bit exp_q[$];
    bit exp_bit;
    int cyc = 0, dclk_edges = 0, ncfg_low = 0, reads = 0;
    int data_rises = 0, tail_rises = 0, err_cyc = 0, drop_cyc = 0, since_rel = 1000;
    logic prev_dclk = 1'b0, prev_err = 1'b0;
    int drop_at = 0, nst_delay = 20;
    bit nst_never = 1'b0, auto_cd = 1'b1;

    ps_bitstream_streamer #(
        .ADDR_W       (AW),
        .DCLK_HALF    (HALF),
        .NCFG_LOW_CYC (NCFG),
        .NSTATUS_TMO  (TMO),
        .EXTRA_DCLK   (EXTRA)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .len_bytes      (len_bytes),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .err_code       (err_code),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .ps_nconfig     (ps_nconfig),
        .ps_nstatus     (ps_nstatus),
        .ps_conf_done   (ps_conf_done),
        .ps_dclk        (ps_dclk),
        .ps_data0       (ps_data0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_chipselect) mem_readdata <= mem[mem_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard plus target model, all sampled on the falling clk edge.
    initial begin : env
        ps_nstatus   = 1'b1;
        ps_conf_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (ps_dclk !== prev_dclk) dclk_edges++;
            if (!ps_nconfig) ncfg_low++;
            if (mem_chipselect) reads++;
            if (error && !prev_err) err_cyc = cyc;
            if (ps_dclk && !prev_dclk) begin
                if (exp_q.size() > 0) begin
                    exp_bit = exp_q.pop_front();
                    check("data_bit", 32'(ps_data0), 32'(exp_bit));
                    data_rises++;
                    if (exp_q.size() == 0 && auto_cd) ps_conf_done = 1'b1;
                end else begin
                    tail_rises++;
                    check("tail_data0", 32'(ps_data0), 32'd1);
                end
            end
            prev_dclk = ps_dclk;
            prev_err  = error;
            if (!ps_nconfig) begin
                ps_nstatus   = 1'b0;
                ps_conf_done = 1'b0;
                since_rel    = 0;
            end else begin
                if (since_rel < 1000) since_rel++;
                if (drop_at > 0 && data_rises >= drop_at) begin
                    if (ps_nstatus) drop_cyc = cyc;
                    ps_nstatus = 1'b0;
                end else if (!nst_never && since_rel >= nst_delay) begin
                    ps_nstatus = 1'b1;
                end
            end
        end
    end

    task automatic push_image(input int b, input int l);
        logic [AW-1:0] a;
        logic [31:0]   w;
        logic [7:0]    by;
        for (int i = 0; i < l; i++) begin
            a  = AW'(b + i / 4);
            w  = mem[a];
            by = 8'(w >> (8 * (i % 4)));
            for (int k = 0; k < 8; k++) exp_q.push_back(by[k]);
        end
    endtask

    task automatic do_start(input int b, input int l);
        @(negedge clk);
        base_addr = AW'(b);
        len_bytes = (AW+2)'(l);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int n = 0;
        while (!((done || error) && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_rises(input int target, input string name);
        int n = 0;
        while (data_rises < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(data_rises >= target), 32'd1);
    endtask

    task automatic run_ok(input int b, input int l, input int delay, input bit poke, input string tag);
        int d0, t0, r0;
        exp_q.delete();
        drop_at = 0; nst_never = 1'b0; auto_cd = 1'b1; nst_delay = delay;
        push_image(b, l);
        d0 = data_rises; t0 = tail_rises; r0 = reads;
        do_start(b, l);
        if (poke) begin
            wait_rises(d0 + 10, {tag, "_poke_wait"});
            do_start(5, 0);
        end
        wait_end(20000, {tag, "_finish"});
        check({tag, "_done"},     32'(done),     32'd1);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_nconfig"},  32'(ps_nconfig), 32'd1);
        check({tag, "_dclk"},     32'(ps_dclk),  32'd0);
        check({tag, "_data_rises"}, 32'(data_rises - d0), 32'(8 * l));
        check({tag, "_tail_rises"}, 32'(tail_rises - t0), 32'(EXTRA));
        check({tag, "_reads"},      32'(reads - r0),      32'((l + 3) / 4));
        check({tag, "_queue_left"}, 32'(exp_q.size()),    32'd0);
    endtask

    initial begin : main
        int n, n0, d0, t0, e0, b, l;
        reset = 1'b1; start = 1'b0; base_addr = '0; len_bytes = '0;
        repeat (3) @(negedge clk);
        check("rst_nconfig",  32'(ps_nconfig), 32'd1);
        check("rst_dclk",     32'(ps_dclk), 32'd0);
        check("rst_data0",    32'(ps_data0), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_error",    32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_cs",       32'(mem_chipselect), 32'd0);
        check("rst_addr",     32'(mem_address), 32'd0);
        check("rst_clken",    32'(mem_clken), 32'd1);
        check("rst_write",    32'(mem_write), 32'd0);
        check("rst_be",       32'(mem_byteenable), 32'hF);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        mem[16'h10] = 32'h04030201;
        mem[16'h11] = 32'h08070605;
        run_ok(16'h10, 8, 20, 1'b0, "eight");

        mem[0] = 32'hDDCCBBAA;
        mem[1] = 32'h000000EE;
        run_ok(0, 5, 7, 1'b1, "five_busy_start");

        n0 = ncfg_low;
        do_start(3, 0);
        check("len0_error",    32'(error), 32'd1);
        check("len0_err_code", 32'(err_code), 32'd3);
        check("len0_busy",     32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        check("len0_nconfig_low", 32'(ncfg_low - n0), 32'd0);

        nst_never = 1'b1;
        n0 = ncfg_low;
        do_start(0, 4);
        n = 0;
        while (!error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("tmo_cycles",   32'(n), 32'(NCFG + TMO));
        check("tmo_err_code", 32'(err_code), 32'd1);
        check("tmo_nconfig",  32'(ps_nconfig), 32'd1);
        check("tmo_busy",     32'(busy), 32'd0);
        check("tmo_ncfg_low", 32'(ncfg_low - n0), 32'(NCFG));
        nst_never = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) mem[16'h20 + i] = $urandom;
        exp_q.delete();
        push_image(16'h20, 16);
        d0 = data_rises;
        drop_at = d0 + 70;
        do_start(16'h20, 16);
        wait_end(5000, "drop_finish");
        check("drop_err_code", 32'(err_code), 32'd2);
        check("drop_latency",  32'(err_cyc - drop_cyc), 32'd1);
        check("drop_nconfig",  32'(ps_nconfig), 32'd1);
        check("drop_dclk",     32'(ps_dclk), 32'd0);
        @(negedge clk);
        e0 = dclk_edges;
        repeat (40) @(negedge clk);
        check("drop_no_edges", 32'(dclk_edges - e0), 32'd0);
        check("drop_rises",    32'(data_rises - d0), 32'd70);
        drop_at = 0;
        repeat (3) @(negedge clk);

        mem[16'h30] = $urandom;
        exp_q.delete();
        auto_cd = 1'b0;
        push_image(16'h30, 4);
        d0 = data_rises; t0 = tail_rises;
        do_start(16'h30, 4);
        wait_end(5000, "nocd_finish");
        check("nocd_error",      32'(error), 32'd1);
        check("nocd_err_code",   32'(err_code), 32'd3);
        check("nocd_data_rises", 32'(data_rises - d0), 32'd32);
        check("nocd_tail_rises", 32'(tail_rises - t0), 32'(8 * EXTRA));
        auto_cd = 1'b1;

        for (int it = 0; it < 6; it++) begin
            b = (it == 0) ? 16382 : int'($urandom_range(0, 16383));
            l = int'($urandom_range(1, 20));
            for (int w = 0; w < (l + 3) / 4; w++) mem[AW'(b + w)] = $urandom;
            run_ok(b, l, int'($urandom_range(1, 30)), 1'b0, "rand");
        end

        exp_q.delete();
        push_image(16'h10, 8);
        d0 = data_rises;
        do_start(16'h10, 8);
        wait_rises(d0 + 10, "rstmid_wait");
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_nconfig", 32'(ps_nconfig), 32'd1);
        check("rstmid_dclk",    32'(ps_dclk), 32'd0);
        check("rstmid_busy",    32'(busy), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        e0 = dclk_edges;
        repeat (40) @(negedge clk);
        check("rstmid_no_edges", 32'(dclk_edges - e0), 32'd0);
        check("rstmid_done",     32'(done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps_bitstream_streamer.md
Name: ps_bitstream_streamer

Overview:
- Consumes bitstream data held in the Nios II on-chip memory through its second port (s2).
- Serialises that data onto a Passive Serial configuration link (nCONFIG/nSTATUS/CONF_DONE/DCLK/DATA0) that drives the target FPGA.
- Software writes the image through s1, then pulses start here; the block then reads s2 and shifts out autonomously.

Parameters:
- ADDR_W, 14, word address width of the memory port.
- DCLK_HALF, 4, clk cycles per DCLK half-period (min 1).
- NCFG_LOW_CYC, 512, clk cycles nCONFIG is held low.
- NSTATUS_TMO, 65536, clk cycles allowed for nSTATUS to rise after nCONFIG release.
- EXTRA_DCLK, 64, DCLK pulses issued after CONF_DONE for device init.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; ignored while busy
- base_addr  in  ADDR_W  first word address of the image
- len_bytes  in  ADDR_W+2  image length in bytes; 0 means immediate error
- busy  out  1  high from accepted start until done or error
- done  out  1  sticky success flag; cleared by next accepted start
- error  out  1  sticky failure flag; cleared by next accepted start
- err_code  out  2  0 = none, 1 = nSTATUS timeout, 2 = nSTATUS low during load, 3 = CONF_DONE missing or zero length
- mem_address  out  ADDR_W  to address2
- mem_chipselect  out  1  to chipselect2
- mem_clken  out  1  to clken2
- mem_write  out  1  to write2; tied 0
- mem_byteenable  out  4  to byteenable2; tied 4'hF
- mem_readdata  in  32  from readdata2; valid one clk after the address is presented
- ps_nconfig  out  1  to target
- ps_nstatus  in  1  from target; already synchronised externally
- ps_conf_done  in  1  from target; already synchronised externally
- ps_dclk  out  1  to target
- ps_data0  out  1  to target

Behaviour:
- Reset values:
  - ps_nconfig=1, ps_dclk=0, ps_data0=0.
  - busy=0, done=0, error=0, err_code=0.
  - mem_chipselect=0, mem_address=0, mem_clken=1.
  - FSM state IDLE.
- Reset mid-operation returns to IDLE next cycle; nCONFIG is released high and no further DCLK edges occur.
- FSM states:
  - IDLE: on start, latch base_addr and len_bytes.
    - len_bytes=0: go to ERR with code 3.
    - Otherwise: busy=1, clear done/error, go to NCFG.
  - NCFG: ps_nconfig=0 for NCFG_LOW_CYC cycles, then release to 1 and go to WAIT_ST.
  - WAIT_ST: nSTATUS=1 goes to FETCH. Timer reaching NSTATUS_TMO goes to ERR with code 1.
  - FETCH: drive mem_address=word pointer with mem_chipselect=1 for 1 cycle, then go to CAPT.
  - CAPT: load mem_readdata into a 32-bit shift register, set bit count = min(32, 8*remaining bytes), increment the word pointer, go to SHIFT.
  - SHIFT:
    - Bit order: byte 0 = readdata[7:0] first; each byte LSB first; the register shifts right.
    - ps_data0 = shreg[0], set while ps_dclk=0.
    - ps_dclk rises after DCLK_HALF cycles and falls after another DCLK_HALF.
    - Shift on the falling edge.
    - After the last bit of the word: remaining>0 goes to FETCH, otherwise to TAIL.
  - TAIL: issue DCLK pulses at the same rate with data0=1.
    - Once CONF_DONE=1 is seen, issue EXTRA_DCLK further pulses, then go to DONE.
    - If 8*EXTRA_DCLK pulses elapse with no CONF_DONE, go to ERR with code 3.
  - DONE: done=1, busy=0, return to IDLE.
  - ERR: error=1, err_code set, busy=0, ps_nconfig=1, ps_dclk=0, return to IDLE.
- nSTATUS=0 in any of FETCH/CAPT/SHIFT/TAIL goes to ERR with code 2. This check has priority over the normal transition in the same cycle.
- The DCLK phase holds low during FETCH/CAPT. The inter-word gap is therefore exactly 2 clk plus the normal low phase; the PS protocol tolerates DCLK stretching.
- Word pointer wraps modulo 2^ADDR_W. No bounds check is made against memory depth (10240 words).
- Byte counter width is ADDR_W+2. A partial last word sends only its valid bytes.

Decomposition:
- Shared package ps_stream_pkg holds:
  - FSM state enum.
  - err_code constants (ERR_NONE, ERR_TMO, ERR_NSTATUS, ERR_CONFDONE).
- One sub-module, ps_dclk_gen: the divider that produces the DCLK level plus rise/fall strobes, with an enable and a synchronous clear.

Test Plan:
- Reset mid-SHIFT (after 10 bits) -> next cycle ps_nconfig=1, ps_dclk=0, busy=0; no DCLK edges afterwards.
- base=0x10, len=8, mem[0x10]=0x04030201, mem[0x11]=0x08070605, nSTATUS high 20 cycles after release, CONF_DONE raised after 64 bits -> DATA0 sampled at DCLK rises = bytes 01..08 LSB-first; 64 extra DCLK pulses; done=1, err_code=0.
- len=5, mem[0]=0xDDCCBBAA, mem[1]=0x000000EE -> exactly 40 data DCLK rises; last byte 0xEE; exactly 2 memory reads.
- nSTATUS held 0 -> error=1, err_code=1 after NCFG_LOW_CYC+NSTATUS_TMO cycles; nCONFIG back high.
- nSTATUS dropped during the 3rd word -> err_code=2 within 1 cycle; no further DCLK edges.
- len=0 -> err_code=3 the cycle after start and nCONFIG never toggles; a start pulse while busy -> ignored, transfer unaffected.
